// File: rtl/rpsd_arbiter_pkg.sv
// Shared types and constants for the RP drive / SD controller arbiter.
package rpsd_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY    = 3'd1,
        ACK     = 3'd2,
        ERR     = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // A disabled watchdog (TIMEOUT=0) still needs a one-bit counter to exist.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rpsd_arbiter_if.sv
// Drive-array and SD-controller signals seen by the arbiter.
// Handshake: each drive holds drvREQ as a level until it sees its one-cycle
// drvACK/drvERR strobe and then drops it; sdREQ is a level held until sdACK.
interface rpsd_arbiter_if #(
    parameter int NDRV = 8,
    parameter int OPW  = 3,
    parameter int LSAW = 21
);
    localparam int UW = $clog2(NDRV);

    logic                 arbMODE;
    logic [NDRV-1:0]      drvREQ;
    logic [NDRV*OPW-1:0]  drvOP;
    logic [NDRV*LSAW-1:0] drvLSA;
    logic [NDRV-1:0]      drvACK;
    logic [NDRV-1:0]      drvERR;
    logic                 sdREQ;
    logic [OPW-1:0]       sdOP;
    logic [LSAW-1:0]      sdLSA;
    logic [UW-1:0]        sdUNIT;
    logic                 sdACK;
    logic                 sdABORT;
    logic                 arbBUSY;

    modport master (
        input  arbMODE, drvREQ, drvOP, drvLSA, sdACK,
        output drvACK, drvERR, sdREQ, sdOP, sdLSA, sdUNIT, sdABORT, arbBUSY
    );

    modport slave (
        output arbMODE, drvREQ, drvOP, drvLSA, sdACK,
        input  drvACK, drvERR, sdREQ, sdOP, sdLSA, sdUNIT, sdABORT, arbBUSY
    );

endinterface

// File: rtl/rpsd_arbiter_rr_pick.sv
// Combinational winner selection: round-robin after `last`, or lowest index.
module rpsd_rr_pick
    import rpsd_arb_pkg::*;
#(
    parameter int NDRV = 8,
    parameter int UW   = $clog2(NDRV)
) (
    input  logic [NDRV-1:0] req,
    input  logic [UW-1:0]   last,
    input  logic            mode,
    output logic [UW-1:0]   winner,
    output logic            valid
);

    int start;
    int idx;

    // Scan from the far end down so the smallest offset from `start` wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        start  = (mode == ARB_FIXED) ? 0 : ((int'(last) + 1) % NDRV);
        for (int off = NDRV - 1; off >= 0; off--) begin
            idx = (start + off) % NDRV;
            if (req[idx]) begin
                winner = UW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rpsd_arbiter.sv
// Shares one SD controller among NDRV drives: grant FSM, operand registers,
// and an optional watchdog that aborts a stuck SD operation.
module rpsd_arbiter
    import rpsd_arb_pkg::*;
#(
    parameter int NDRV    = 8,
    parameter int OPW     = 3,
    parameter int LSAW    = 21,
    parameter int TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    rpsd_arbiter_if.master bus,
    output state_t         dbg_state
);

    localparam int UW  = $clog2(NDRV);
    localparam int WDW = wd_width(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state_q;
    state_t          state_d;
    logic [UW-1:0]   unit_q;
    logic [OPW-1:0]  op_q;
    logic [LSAW-1:0] lsa_q;
    logic [UW-1:0]   last_q;
    logic [WDW-1:0]  wd_q;
    logic [UW-1:0]   pick_w;
    logic            pick_v;
    logic [NDRV-1:0] unit_oh;

    rpsd_rr_pick #(.NDRV(NDRV), .UW(UW)) u_pick (
        .req    (bus.drvREQ),
        .last   (last_q),
        .mode   (bus.arbMODE),
        .winner (pick_w),
        .valid  (pick_v)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_v) state_d = BUSY;
            BUSY: begin
                if (bus.sdACK) state_d = ACK;
                else if (TIMEOUT != 0 && wd_q == WD_LAST) state_d = ERR;
            end
            ACK:     state_d = RELEASE;
            ERR:     state_d = RELEASE;
            // Hold off re-arbitration until the owner lets go of its request.
            RELEASE: if (!bus.drvREQ[unit_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            unit_q  <= '0;
            op_q    <= '0;
            lsa_q   <= '0;
            last_q  <= UW'(NDRV - 1);
            wd_q    <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            unit_q  <= '0;
            op_q    <= '0;
            lsa_q   <= '0;
            last_q  <= UW'(NDRV - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_v) begin
                unit_q <= pick_w;
                op_q   <= bus.drvOP[pick_w * OPW +: OPW];
                lsa_q  <= bus.drvLSA[pick_w * LSAW +: LSAW];
                last_q <= pick_w;
                wd_q   <= '0;
            end else if (state_q == BUSY && wd_q != '1) begin
                wd_q <= wd_q + WDW'(1);
            end
        end
    end

    // Every output is a decode of registered state only.
    assign unit_oh     = {{(NDRV-1){1'b0}}, 1'b1} << unit_q;
    assign bus.sdREQ   = (state_q == BUSY);
    assign bus.sdOP    = op_q;
    assign bus.sdLSA   = lsa_q;
    assign bus.sdUNIT  = unit_q;
    assign bus.drvACK  = (state_q == ACK) ? unit_oh : '0;
    assign bus.drvERR  = (state_q == ERR) ? unit_oh : '0;
    assign bus.sdABORT = (state_q == ERR);
    assign bus.arbBUSY = (state_q != IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rpsd_arbiter.sv
// Directed bench for rpsd_arbiter with a grant/strobe scoreboard.
module tb_rpsd_arbiter;
    import rpsd_arb_pkg::*;

    localparam int NDRV = 8;
    localparam int OPW  = 3;
    localparam int LSAW = 21;
    localparam int TMO  = 16;
    localparam int GW   = 3 + OPW + LSAW;
    localparam int SW   = NDRV + NDRV + 1;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   clr = 1'b0;
    state_t dbg_state;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;

    logic [GW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [SW-1:0] exp_s_q[$];
    int            exp_s_cyc_q[$];

    logic [OPW-1:0]  op_tab  [NDRV];
    logic [LSAW-1:0] lsa_tab [NDRV];

    rpsd_arbiter_if #(.NDRV(NDRV), .OPW(OPW), .LSAW(LSAW)) bus ();

    rpsd_arbiter #(.NDRV(NDRV), .OPW(OPW), .LSAW(LSAW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [NDRV-1:0] mk_oh(input int u);
        logic [NDRV-1:0] one;
        one = 1;
        return one << u;
    endfunction

    function automatic logic [GW-1:0] mk_grant(input int u);
        logic [2:0] uu;
        uu = 3'(u);
        return {uu, op_tab[u], lsa_tab[u]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_drive(input int i, input logic [OPW-1:0] op, input logic [LSAW-1:0] lsa);
        op_tab[i]  = op;
        lsa_tab[i] = lsa;
        bus.drvOP[i*OPW +: OPW]    = op;
        bus.drvLSA[i*LSAW +: LSAW] = lsa;
    endtask

    task automatic wait_grant(output int g);
        int n;
        n = 0;
        while (!bus.sdREQ && n < 64) begin
            tick();
            n++;
        end
        if (!bus.sdREQ) begin
            checks++;
            errors++;
            $display("FAIL grant_wait got=no_sdREQ exp=sdREQ within 64 cycles (cycle %0d)", cyc);
        end
        g = cyc;
    endtask

    task automatic do_txn(input int u, input int ack_dly, input int hold, input bit reraise);
        int g;
        wait_grant(g);
        repeat (ack_dly) tick();
        exp_s_q.push_back({mk_oh(u), {NDRV{1'b0}}, 1'b0});
        exp_s_cyc_q.push_back(g + ack_dly + 1);
        bus.sdACK = 1'b1;
        tick();
        bus.sdACK = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_no_regrant", 64'(bus.sdREQ), 64'd0);
        end
        bus.drvREQ[u] = 1'b0;
        tick();
        tick();
        if (reraise) bus.drvREQ[u] = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          prev_req = 1'b0;
    logic [GW-1:0] cur_g    = '0;

    always @(negedge clk) begin
        logic [GW-1:0] act_g;
        logic [SW-1:0] act_s;
        logic [GW-1:0] e;
        logic [SW-1:0] es;
        int            c;
        if (!rst) begin
            act_g = {bus.sdUNIT, bus.sdOP, bus.sdLSA};
            act_s = {bus.drvACK, bus.drvERR, bus.sdABORT};
            if (bus.sdREQ && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected got=%0h exp=none (cycle %0d)", act_g, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("grant_unit_op_lsa", 64'(act_g), 64'(e));
                    if (c >= 0) check("grant_cycle", 64'(cyc), 64'(c));
                end
                cur_g = act_g;
            end else if (bus.sdREQ) begin
                check("busy_operands_stable", 64'(act_g), 64'(cur_g));
            end
            prev_req = bus.sdREQ;

            if (act_s != '0) begin
                if (exp_s_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected got=%0h exp=none (cycle %0d)", act_s, cyc);
                end else begin
                    es = exp_s_q.pop_front();
                    c  = exp_s_cyc_q.pop_front();
                    check("strobe_ack_err_abort", 64'(act_s), 64'(es));
                    if (c >= 0) check("strobe_cycle", 64'(cyc), 64'(c));
                end
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        int t0;
        int rr_order [6];
        rr_order = '{2, 5, 7, 2, 5, 7};

        bus.arbMODE = ARB_RR;
        bus.drvREQ  = '0;
        bus.drvOP   = '0;
        bus.drvLSA  = '0;
        bus.sdACK   = 1'b0;
        for (int i = 0; i < NDRV; i++)
            set_drive(i, OPW'(i + 1), LSAW'(21'h01000 * i + 21'h000A0 + i));

        repeat (3) tick();
        check("rst_sdREQ", 64'(bus.sdREQ), 64'd0);
        check("rst_arbBUSY", 64'(bus.arbBUSY), 64'd0);
        rst = 1'b0;
        check("rst_operands", 64'({bus.sdUNIT, bus.sdOP, bus.sdLSA}), 64'd0);
        check("rst_strobes", 64'({bus.drvACK, bus.drvERR, bus.sdABORT}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        tick();

        // Round-robin among drives 2, 5, 7
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk_grant(rr_order[k]));
            exp_cyc_q.push_back(-1);
        end
        bus.drvREQ[2] = 1'b1;
        bus.drvREQ[5] = 1'b1;
        bus.drvREQ[7] = 1'b1;
        for (int k = 0; k < 6; k++) do_txn(rr_order[k], 4, 0, k < 3);
        tick();

        // Fixed priority: drive 1 always beats drive 6
        bus.arbMODE = ARB_FIXED;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_grant(1));
            exp_cyc_q.push_back(-1);
        end
        exp_q.push_back(mk_grant(6));
        exp_cyc_q.push_back(-1);
        bus.drvREQ[1] = 1'b1;
        bus.drvREQ[6] = 1'b1;
        do_txn(1, 2, 0, 1);
        do_txn(1, 2, 0, 1);
        do_txn(1, 2, 0, 0);
        do_txn(6, 2, 0, 0);
        bus.arbMODE = ARB_RR;
        tick();

        // Handshake latency: drive 3, op 5, lsa 0x12345
        set_drive(3, 3'd5, 21'h12345);
        t0 = cyc;
        exp_q.push_back({3'd3, 3'd5, 21'h12345});
        exp_cyc_q.push_back(t0 + 1);
        bus.drvREQ[3] = 1'b1;
        do_txn(3, 9, 0, 0);
        tick();

        // Watchdog expiry on drive 5 (last=3, so 5 is next)
        exp_q.push_back(mk_grant(5));
        exp_cyc_q.push_back(-1);
        bus.drvREQ[5] = 1'b1;
        wait_grant(g);
        exp_s_q.push_back({{NDRV{1'b0}}, mk_oh(5), 1'b1});
        exp_s_cyc_q.push_back(g + TMO);
        repeat (TMO) tick();
        bus.drvREQ[5] = 1'b0;
        tick();
        tick();

        // sdACK in the very cycle the watchdog would fire: ack wins
        exp_q.push_back(mk_grant(6));
        exp_cyc_q.push_back(-1);
        bus.drvREQ[6] = 1'b1;
        do_txn(6, TMO - 1, 0, 0);
        tick();

        // Hold/release: drive 0 keeps its request 10 cycles past its ack
        exp_q.push_back(mk_grant(0));
        exp_cyc_q.push_back(-1);
        exp_q.push_back(mk_grant(4));
        exp_cyc_q.push_back(-1);
        bus.drvREQ[0] = 1'b1;
        bus.drvREQ[4] = 1'b1;
        do_txn(0, 2, 10, 0);
        do_txn(4, 2, 0, 0);
        tick();

        // clr during BUSY on drive 2 (last=4 so 2 is granted)
        exp_q.push_back(mk_grant(2));
        exp_cyc_q.push_back(-1);
        bus.drvREQ[2] = 1'b1;
        wait_grant(g);
        repeat (3) tick();
        clr = 1'b1;
        bus.drvREQ[2] = 1'b0;
        tick();
        clr = 1'b0;
        check("clr_sdREQ", 64'(bus.sdREQ), 64'd0);
        check("clr_arbBUSY", 64'(bus.arbBUSY), 64'd0);
        check("clr_state", 64'(dbg_state), 64'(IDLE));
        check("clr_operands", 64'({bus.sdUNIT, bus.sdOP, bus.sdLSA}), 64'd0);
        check("clr_strobes", 64'({bus.drvACK, bus.drvERR, bus.sdABORT}), 64'd0);
        tick();
        // After clr round-robin restarts at 0: drive 1 precedes drive 5
        exp_q.push_back(mk_grant(1));
        exp_cyc_q.push_back(-1);
        exp_q.push_back(mk_grant(5));
        exp_cyc_q.push_back(-1);
        bus.drvREQ[1] = 1'b1;
        bus.drvREQ[5] = 1'b1;
        do_txn(1, 2, 0, 0);
        do_txn(5, 2, 0, 0);

        repeat (5) tick();
        check("grants_drained", 64'(exp_q.size()), 64'd0);
        check("strobes_drained", 64'(exp_s_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL global_timeout got=still_running exp=finished (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
